// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
//   Instruction-fetch front end. Issues word fetches ahead of decode into a
//   DEPTH-entry queue of {pc, instr}. A redirect flushes the queue, drops any
//   stale response and restarts fetch at the new target in the same cycle.
//   Optional feature macro: FETCH_JAL_PREDICT_EN. When it is defined, JALs
//   are followed at fetch time and the entry is marked with instr_pred_o.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_pred_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // Occupancy is compared one bit wider than count so count + inflight never wraps.
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Fetch-side state
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic             inflight_reg, inflight_next;
  logic [31:0]      inflight_pc_reg, inflight_pc_next;

  // Queue bookkeeping
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Queue storage (no reset needed: count gates visibility)
  logic [31:0]      q_pc_reg    [DEPTH];
  logic [31:0]      q_instr_reg [DEPTH];

  // Combinational helpers
  logic [31:0]      redirect_addr;
  logic [31:0]      req_addr;
  logic [CNT_W:0]   occupancy;
  logic             req_raw;
  logic             accept;
  logic             push;
  logic             pop;
  logic             kill_active;
  logic             unused_redirect_bits;

  // Low address bits of the redirect target are discarded by design.
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  assign redirect_addr = {redirect_pc_i[31:2], 2'b00};
  // Zero-bubble redirect: the target is requested in the same cycle.
  assign req_addr      = redirect_i ? redirect_addr : fetch_pc_reg;
  // Entries already queued plus the one response that may still arrive.
  assign occupancy     = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
  assign req_raw       = redirect_i | (occupancy < DEPTH_OCC);

  // Outputs are forced low while reset is asserted.
  assign imem_req_o    = rstn_i & req_raw;
  assign imem_addr_o   = rstn_i ? req_addr : 32'h0;

  assign accept        = imem_req_o & imem_ready_i;
  // A response is only taken if it belongs to a live, non-squashed request.
  assign push          = imem_rvalid_i & inflight_reg & ~kill_active & ~redirect_i;
  // A redirect overrides any consumption by decode this cycle.
  assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

  assign instr_valid_o = (count_reg != '0);
  assign instr_o       = instr_valid_o ? q_instr_reg[rd_ptr_reg] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? q_pc_reg[rd_ptr_reg] : 32'h0;

`ifdef FETCH_JAL_PREDICT_EN
  logic        kill_reg, kill_next;
  logic        q_pred_reg [DEPTH];
  logic        is_jal;
  logic [31:0] jal_offset;
  logic [31:0] jal_target;

  assign kill_active = kill_reg;
  assign is_jal      = (imem_rdata_i[6:0] == 7'b1101111);
  // J-immediate, with imm[1] dropped so the target stays word aligned.
  assign jal_offset  = {{11{imem_rdata_i[31]}}, imem_rdata_i[31], imem_rdata_i[19:12],
                        imem_rdata_i[20], imem_rdata_i[30:22], 2'b00};
  assign jal_target  = inflight_pc_reg + jal_offset;

  // Squash the sequential fetch issued in the same cycle a JAL is queued.
  always_comb begin
    kill_next = 1'b0;
    if (!redirect_i && push && is_jal && accept) begin
      kill_next = 1'b1;
    end
  end

  // Kill flag lives for exactly the one cycle until the squashed response returns.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kill_reg <= 1'b0;
    end else begin
      kill_reg <= kill_next;
    end
  end

  // Prediction bit travels alongside the queued entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pred_reg[wr_ptr_reg] <= is_jal;
    end
  end

  assign instr_pred_o = instr_valid_o & q_pred_reg[rd_ptr_reg];
`else
  assign kill_active  = 1'b0;
  assign instr_pred_o = 1'b0;
`endif

  // Next fetch address: sequential after an accept, held otherwise, retargeted on redirect.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (accept) begin
      fetch_pc_next = req_addr + 32'd4;
    end else if (redirect_i) begin
      fetch_pc_next = redirect_addr;
    end
`ifdef FETCH_JAL_PREDICT_EN
    // A queued JAL takes precedence over the sequential address.
    if (push && is_jal) begin
      fetch_pc_next = jal_target;
    end
`endif
  end

  // Track the single outstanding request and its address.
  always_comb begin
    inflight_next    = accept;
    inflight_pc_next = inflight_pc_reg;
    if (accept) begin
      inflight_pc_next = req_addr;
    end
  end

  // Queue pointers and occupancy; redirect empties the queue outright.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!push && pop) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc_reg    <= {RESET_PC[31:2], 2'b00};
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // Queue data write at the tail; the head is read combinationally.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc_reg[wr_ptr_reg]    <= inflight_pc_reg;
      q_instr_reg[wr_ptr_reg] <= imem_rdata_i;
    end
  end

endmodule
